// File: rtl/rand_feed_if.sv
// Handshake bundle between rand_feed and its seed source / randomness consumer.
// The "slave" view belongs to rand_feed: it accepts seed words and serves r.
// The "master" view belongs to the surrounding logic: it offers seeds and takes r.
interface rand_feed_if;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        seed_ready;
  logic [89:0] r;
  logic        r_valid;
  logic        r_ready;
  logic        reseed_req;

  modport master (
    output seed_valid, seed_data, r_ready,
    input  seed_ready, r, r_valid, reseed_req
  );

  modport slave (
    input  seed_valid, seed_data, r_ready,
    output seed_ready, r, r_valid, reseed_req
  );
endinterface

// File: rtl/rand_feed.sv
// rand_feed: 128-bit LFSR randomness source for a masked S-box stage.
// A 4-word seed loads the state, each consumed output advances it by 90 steps,
// and after RESEED_LIMIT outputs the block stalls until it is reseeded.
module rand_feed #(
  parameter int unsigned RESEED_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  rand_feed_if.slave  bus
);

  typedef enum logic [1:0] {UNSEEDED, LOADING, RUN, EXHAUSTED} state_t;

  localparam logic [16:0] LIMIT = 17'(RESEED_LIMIT);

  state_t       state_q, state_d;
  logic [127:0] s_q, s_d;
  logic [1:0]   wcnt_q, wcnt_d;
  logic [15:0]  ocnt_q, ocnt_d;
  logic         r_valid_q, r_valid_d;
  logic         reseed_req_q, reseed_req_d;
  logic         seed_ready_q;

  logic         accept;
  logic         take;
  logic [127:0] load_word;
  logic [16:0]  ocnt_inc;

  // 90 LFSR steps unrolled into one combinational cloud.
  function automatic logic [127:0] step90(input logic [127:0] x);
    logic [127:0] v;
    v = x;
    for (int i = 0; i < 90; i++) begin
      v = {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
    end
    return v;
  endfunction

  // Next-state logic: a seed word always wins over an output handshake.
  always_comb begin
    accept    = bus.seed_valid & seed_ready_q;
    take      = r_valid_q & bus.r_ready;
    load_word = {s_q[95:0], bus.seed_data};
    ocnt_inc  = {1'b0, ocnt_q} + 17'd1;

    state_d = state_q;
    s_d     = s_q;
    wcnt_d  = wcnt_q;
    ocnt_d  = ocnt_q;

    if (accept) begin
      if (wcnt_q == 2'd3) begin
        // An all-zero seed would lock the LFSR, so substitute 1.
        s_d     = step90((load_word == 128'd0) ? 128'h1 : load_word);
        wcnt_d  = 2'd0;
        ocnt_d  = 16'd0;
        state_d = RUN;
      end else begin
        s_d    = load_word;
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == 2'd0) begin
          state_d = LOADING;
        end
      end
    end else if (take) begin
      s_d    = step90(s_q);
      ocnt_d = ocnt_inc[15:0];
      if (ocnt_inc == LIMIT) begin
        state_d = EXHAUSTED;
      end
    end

    r_valid_d    = (state_d == RUN);
    reseed_req_d = (state_d == EXHAUSTED);
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNSEEDED;
      s_q          <= '0;
      wcnt_q       <= '0;
      ocnt_q       <= '0;
      r_valid_q    <= 1'b0;
      reseed_req_q <= 1'b0;
      seed_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      wcnt_q       <= wcnt_d;
      ocnt_q       <= ocnt_d;
      r_valid_q    <= r_valid_d;
      reseed_req_q <= reseed_req_d;
      seed_ready_q <= 1'b1;
    end
  end

  assign bus.r          = s_q[89:0];
  assign bus.r_valid    = r_valid_q;
  assign bus.reseed_req = reseed_req_q;
  assign bus.seed_ready = seed_ready_q;

endmodule

// File: tb/tb_rand_feed.sv
// Bench for rand_feed: vector table plus reset-related hand sequences,
// with a behavioural model feeding an expectation queue.
module tb_rand_feed;

  localparam int LIMIT  = 3;
  localparam int M_UNS  = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_EXH  = 3;

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        rr;
    logic        ev;
    logic        er;
    logic        has_r;
    logic [89:0] exp_r;
  } vec_t;

  typedef struct {
    logic [89:0] r;
    logic        vld;
    logic        req;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  rand_feed_if bus ();

  rand_feed #(.RESEED_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  exp_t sb[$];

  logic [127:0] m_s;
  int           m_st;
  logic [1:0]   m_w;
  int           m_o;

  function automatic logic [127:0] ref_step90(input logic [127:0] x);
    logic [127:0] s;
    s = x;
    for (int i = 0; i < 90; i++) s = {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
    return s;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s  = '0;
    m_st = M_UNS;
    m_w  = 2'd0;
    m_o  = 0;
  endtask

  task automatic model_cycle(input logic sv, input logic [31:0] sd, input logic rr);
    logic [127:0] l;
    if (sv) begin
      l = {m_s[95:0], sd};
      if (m_w == 2'd3) begin
        if (l == 128'd0) l = 128'h1;
        m_s  = ref_step90(l);
        m_w  = 2'd0;
        m_o  = 0;
        m_st = M_RUN;
      end else begin
        if (m_w == 2'd0) m_st = M_LOAD;
        m_s = l;
        m_w = m_w + 2'd1;
      end
    end else if (m_st == M_RUN && rr) begin
      m_s = ref_step90(m_s);
      m_o++;
      if (m_o == LIMIT) m_st = M_EXH;
    end
  endtask

  function automatic vec_t mk(input logic sv, input logic [31:0] sd, input logic rr,
                              input logic ev, input logic er, input logic has_r,
                              input logic [89:0] exp_r);
    vec_t v;
    v.sv = sv; v.sd = sd; v.rr = rr; v.ev = ev; v.er = er;
    v.has_r = has_r; v.exp_r = exp_r;
    return v;
  endfunction

  // One clock: drive inputs, push the expectation, then pop and compare after the edge.
  task automatic cyc(input vec_t v, input string nm);
    exp_t e;
    bus.seed_valid = v.sv;
    bus.seed_data  = v.sd;
    bus.r_ready    = v.rr;
    model_cycle(v.sv, v.sd, v.rr);
    e.r   = m_s[89:0];
    e.vld = v.ev;
    e.req = v.er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({nm, " r"},          {38'd0, bus.r},      {38'd0, e.r});
    check({nm, " r_valid"},    {127'd0, bus.r_valid},    {127'd0, e.vld});
    check({nm, " reseed_req"}, {127'd0, bus.reseed_req}, {127'd0, e.req});
    check({nm, " seed_ready"}, {127'd0, bus.seed_ready}, 128'd1);
    if (v.has_r) check({nm, " r_direct"}, {38'd0, bus.r}, {38'd0, v.exp_r});
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " r"},          {38'd0, bus.r},           128'd0);
    check({nm, " r_valid"},    {127'd0, bus.r_valid},    128'd0);
    check({nm, " reseed_req"}, {127'd0, bus.reseed_req}, 128'd0);
    check({nm, " seed_ready"}, {127'd0, bus.seed_ready}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t;
    logic [127:0] sd_b;
    logic [127:0] sd_c;
    logic [127:0] sd_d;

    bus.seed_valid = 1'b0;
    bus.seed_data  = '0;
    bus.r_ready    = 1'b0;
    rst_n          = 1'b0;
    model_reset();

    // Vector table
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 32'h0, 0, 0, 0, 0, '0));
    t = ref_step90(128'h1);
    vecs.push_back(mk(1, 32'h0, 0, 1, 0, 1, t[89:0]));

    sd_b = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
    vecs.push_back(mk(1, 32'h01234567, 0, 0, 0, 0, '0));
    vecs.push_back(mk(1, 32'h89ABCDEF, 1, 0, 0, 0, '0));
    vecs.push_back(mk(1, 32'hFEDCBA98, 0, 0, 0, 0, '0));
    t = ref_step90(sd_b);
    vecs.push_back(mk(1, 32'h76543210, 0, 1, 0, 1, t[89:0]));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 0, 1, t[89:0]));
    for (int k = 0; k < 3; k++) begin
      t = ref_step90(t);
      vecs.push_back(mk(0, 32'h0, 1, (k < 2), (k == 2), 1, t[89:0]));
    end
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, t[89:0]));

    sd_c = {32'hDEADBEEF, 32'h00000000, 32'hCAFEF00D, 32'h13579BDF};
    vecs.push_back(mk(1, 32'hDEADBEEF, 0, 0, 0, 0, '0));
    vecs.push_back(mk(1, 32'h00000000, 1, 0, 0, 0, '0));
    vecs.push_back(mk(1, 32'hCAFEF00D, 0, 0, 0, 0, '0));
    t = ref_step90(sd_c);
    vecs.push_back(mk(1, 32'h13579BDF, 0, 1, 0, 1, t[89:0]));
    t = ref_step90(t);
    vecs.push_back(mk(0, 32'h0, 1, 1, 0, 1, t[89:0]));
    t = {t[95:0], 32'hA5A5A5A5};
    vecs.push_back(mk(1, 32'hA5A5A5A5, 1, 0, 0, 1, t[89:0]));
    vecs.push_back(mk(1, 32'h5A5A5A5A, 0, 0, 0, 0, '0));
    vecs.push_back(mk(1, 32'h0F0F0F0F, 1, 0, 0, 0, '0));
    t = ref_step90({32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0});
    vecs.push_back(mk(1, 32'hF0F0F0F0, 0, 1, 0, 1, t[89:0]));
    for (int k = 0; k < 3; k++) begin
      t = ref_step90(t);
      vecs.push_back(mk(0, 32'h0, 1, (k < 2), (k == 2), 1, t[89:0]));
    end

    // Reset state, asserted from time zero
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    check({"release seed_ready_before_edge"}, {127'd0, bus.seed_ready}, 128'd0);
    cyc(mk(0, 32'h0, 1, 0, 0, 0, '0), "release idle");

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i], $sformatf("row%0d", i));
    end

    // Reset in the middle of a seed load discards the partial words
    cyc(mk(1, 32'h11111111, 0, 0, 0, 0, '0), "partial w0");
    cyc(mk(1, 32'h22222222, 0, 0, 0, 0, '0), "partial w1");
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midload reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("midload reset held");
    rst_n = 1'b1;
    cyc(mk(0, 32'h0, 0, 0, 0, 0, '0), "midload release idle");
    sd_d = {32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
    t = ref_step90(sd_d);
    cyc(mk(1, 32'h33333333, 0, 0, 0, 0, '0), "reload w0");
    cyc(mk(1, 32'h44444444, 0, 0, 0, 0, '0), "reload w1");
    cyc(mk(1, 32'h55555555, 0, 0, 0, 0, '0), "reload w2");
    cyc(mk(1, 32'h66666666, 0, 1, 0, 1, t[89:0]), "reload w3");
    cyc(mk(0, 32'h0, 0, 1, 0, 1, t[89:0]), "reload hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rand_feed.md
RAND_FEED -- requirements
Module: rand_feed

Interface
REQ-001 SHALL have parameter RESEED_LIMIT, default 65535; maximum handshakes allowed per seed.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port seed_valid  input  1  seed word offered.
REQ-005 SHALL have port seed_data  input  32  seed word, first word becomes S[127:96].
REQ-006 SHALL have port seed_ready  output  1  seed word acceptance; constant 1 outside reset.
REQ-007 SHALL have port r  output  90  fresh mask randomness for the two-share-pair masked S-box stage; r[44:0] lower nibble, r[89:45] upper nibble.
REQ-008 SHALL have port r_valid  output  1  r is fresh and may be consumed.
REQ-009 SHALL have port r_ready  input  1  consumer takes r this cycle.
REQ-010 SHALL have port reseed_req  output  1  output budget exhausted, reseed needed.

Function
REQ-011 SHALL hold a 128-bit state register S, a 2-bit seed word counter wcnt and a 16-bit output counter ocnt.
REQ-012 SHALL define one step as: fb = S[127]^S[125]^S[100]^S[98]; S' = {S[126:0], fb}.
REQ-013 SHALL define step90(X) as 90 consecutive steps applied to X within one cycle.
REQ-014 SHALL drive r = S[89:0] directly from the register (no combinational path from inputs).
REQ-015 SHALL implement FSM states UNSEEDED, LOADING, RUN, EXHAUSTED.
REQ-016 SHALL accept a seed word on every cycle with seed_valid=1 (seed_ready=1), in any state.
REQ-017 SHALL, on an accepted word, update S <= {S[95:0], seed_data} and increment wcnt (mod 4).
REQ-018 SHALL go UNSEEDED/RUN/EXHAUSTED -> LOADING on an accepted word with wcnt=0.
REQ-019 SHALL, on the 4th accepted word (wcnt=3), set S <= step90(L), where L = {S[95:0], seed_data}, or L = 128'h1 if that value is all-zero; clear ocnt; go to RUN.
REQ-020 SHALL assert r_valid only in RUN; r_valid=0 in UNSEEDED, LOADING, EXHAUSTED.
REQ-021 SHALL, in RUN with r_valid&r_ready and no accepted seed word, set S <= step90(S) and ocnt <= ocnt+1.
REQ-022 SHALL hold S and r unchanged in RUN while r_ready=0.
REQ-023 SHALL, when an accepted seed word and a handshake coincide in RUN, apply only the seed shift (REQ-017/018); ocnt not incremented.
REQ-024 SHALL go RUN -> EXHAUSTED in the cycle after the handshake that makes ocnt equal RESEED_LIMIT.
REQ-025 SHALL assert reseed_req exactly while in EXHAUSTED; only a full 4-word seed leaves EXHAUSTED.
REQ-026 SHALL ignore r_ready outside RUN (no stepping, no counting).
REQ-027 SHALL complete at most one output per cycle; latency from 4th seed word to r_valid=1 is one cycle.

Reset
REQ-028 SHALL, while rst_n=0, force: state UNSEEDED, S=0, wcnt=0, ocnt=0, r=0, r_valid=0, reseed_req=0, seed_ready=0.
REQ-029 SHALL drive seed_ready=1 from the first clock edge after rst_n deasserts.
REQ-030 SHALL discard any partially loaded seed on reset; a new seed restarts from word 0.

Verification
REQ-031 SHALL cover: reset release, seed 0,0,0,0 -> next cycle r_valid=1, S = step90(128'h1), reseed_req=0.
REQ-032 SHALL cover: seed 32'h01234567,89ABCDEF,FEDCBA98,76543210, r_ready low 10 cycles -> r stable and equal to step90(seed)[89:0]; then 3 handshakes -> r matches the reference model at each step.
REQ-033 SHALL cover: RESEED_LIMIT=3, 3 handshakes -> r_valid=0, reseed_req=1 next cycle; further r_ready ignored; new 4-word seed -> RUN, reseed_req=0, ocnt=0.
REQ-034 SHALL cover: RUN, first reseed word coincident with r_ready=1 -> r_valid=0 next cycle, ocnt unchanged, S shifted by seed word.
REQ-035 SHALL cover: rst_n pulsed low after 2 of 4 seed words -> all outputs at reset values; 4 new words -> r equals step90 of new seed only.
